sha512_block_core: RTL and testbench

Iterative SHA-512 compression engine (FIPS 180-4). It takes a 512-bit chaining value and one padded 1024-bit message block, and runs 80 rounds at one round per clock. It then adds the result into the chaining value and presents the new 512-bit hash with a one-cycle valid pulse. It sits under the hashing front end, which handles padding and multi-block chaining; the front end feeds H_in from the standard IV for the first block.

---
 rtl/sha512_pkg.sv | 83 ++++++++
 rtl/sha512_k_rom.sv | 14 +
 rtl/sha512_block_core.sv | 113 +++++++++++
 tb/tb_sha512_block_core.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sha512_pkg.sv
// rtl/sha512_pkg.sv - SHA-512 constants, round functions and FSM state type
// Purpose: shared definitions for sha512_block_core and sha512_k_rom.
//   SHA512_K  : 80 round constants, SHA512_K[0] = K0
//   SHA512_IV : initial hash value, IV[511:448] = H0 ... IV[63:0] = H7
//   Functions : big_sigma0/1, small_sigma0/1, ch, maj, add512 (per-word add)
// Optional feature macro used by the core: SHA512_FUSED_FINAL_EN
package sha512_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL
  } sha512_state_e;

  localparam logic [511:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [0:79][63:0] SHA512_K = {
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] big_sigma0(input logic [63:0] x);
    return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
  endfunction

  function automatic logic [63:0] big_sigma1(input logic [63:0] x);
    return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
  endfunction

  function automatic logic [63:0] small_sigma0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] small_sigma1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  function automatic logic [63:0] ch(input logic [63:0] e, input logic [63:0] f,
                                     input logic [63:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [63:0] maj(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Eight independent mod-2^64 additions; carries never cross word boundaries.
  function automatic logic [511:0] add512(input logic [511:0] x, input logic [511:0] y);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*64 +: 64] = x[i*64 +: 64] + y[i*64 +: 64];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha512_k_rom.sv
// rtl/sha512_k_rom.sv - combinational SHA-512 round-constant ROM
// Purpose: maps round index to K[t].
//   idx_i [6:0]  round index 0..79 (larger values return 0)
//   k_o   [63:0] round constant
module sha512_k_rom
  import sha512_pkg::*;
(
  input  logic [6:0]  idx_i,
  output logic [63:0] k_o
);

  assign k_o = (idx_i < 7'd80) ? SHA512_K[idx_i] : 64'h0;

endmodule

// File: rtl/sha512_block_core.sv
// rtl/sha512_block_core.sv - iterative SHA-512 compression, one round per clock
// Purpose: compresses one 1024-bit block into a 512-bit chaining value.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   H_in  [511:0]  chaining value, H0 in [511:448]
//   M_in  [1023:0] padded block, W0 in [1023:960]
//   input_valid  start request, sampled only in IDLE
//   H_out [511:0]  new chaining value, held until next completion
//   output_valid one-cycle pulse when H_out is updated
// Macro SHA512_FUSED_FINAL_EN: fold the feed-forward add into round 79
//   (80-clock latency instead of 81).
module sha512_block_core
  import sha512_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [511:0]  H_in,
  input  logic [1023:0] M_in,
  input  logic          input_valid,
  output logic [511:0]  H_out,
  output logic          output_valid
);

  sha512_state_e    state_q, state_d;
  logic [6:0]       t_q, t_d;
  // Word 7 = a ... word 0 = h, so loading H_in directly lines up with H0..H7.
  logic [7:0][63:0] v_q, v_d;
  logic [511:0]     hs_q, hs_d;
  // Window holds W_t..W_t+15 with W_t in word 15; new words enter at word 0.
  logic [15:0][63:0] w_q, w_d;
  logic [511:0]     hout_q, hout_d;
  logic             ov_q, ov_d;

  logic [63:0]      k_t, t1, t2, w_next;
  logic [7:0][63:0] round_v;

  sha512_k_rom u_k_rom (
    .idx_i (t_q),
    .k_o   (k_t)
  );

  assign t1 = v_q[0] + big_sigma1(v_q[3]) + ch(v_q[3], v_q[2], v_q[1]) + k_t + w_q[15];
  assign t2 = big_sigma0(v_q[7]) + maj(v_q[7], v_q[6], v_q[5]);
  assign round_v = {t1 + t2, v_q[7], v_q[6], v_q[5], v_q[4] + t1, v_q[3], v_q[2], v_q[1]};

  // W_t+16 from W_t+14, W_t+9, W_t+1, W_t. Words produced past W79 are never used.
  assign w_next = small_sigma1(w_q[1]) + w_q[6] + small_sigma0(w_q[14]) + w_q[15];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    v_d     = v_q;
    hs_d    = hs_q;
    w_d     = w_q;
    hout_d  = hout_q;
    ov_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (input_valid) begin
          hs_d    = H_in;
          v_d     = H_in;
          w_d     = M_in;
          t_d     = 7'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        v_d = round_v;
        w_d = {w_q[14:0], w_next};
        t_d = t_q + 7'd1;
        if (t_q == 7'd79) begin
`ifdef SHA512_FUSED_FINAL_EN
          hout_d  = add512(hs_q, round_v);
          ov_d    = 1'b1;
          state_d = ST_IDLE;
`else
          state_d = ST_FINAL;
`endif
        end
      end
      ST_FINAL: begin
        hout_d  = add512(hs_q, v_q);
        ov_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      v_q     <= '0;
      hs_q    <= '0;
      w_q     <= '0;
      hout_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      w_q     <= w_d;
      hout_q  <= hout_d;
      ov_q    <= ov_d;
    end
  end

  assign H_out        = hout_q;
  assign output_valid = ov_q;

endmodule

// File: tb/tb_sha512_block_core.sv
// tb/tb_sha512_block_core.sv - self-checking bench for sha512_block_core
module tb_sha512_block_core;

`ifdef SHA512_FUSED_FINAL_EN
  localparam int LAT = 80;
`else
  localparam int LAT = 81;
`endif

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [1023:0] ABC_M   = {64'h6162638000000000, 896'h0, 64'h18};
  localparam logic [1023:0] EMPTY_M = {64'h8000000000000000, 960'h0};
  localparam logic [511:0] ABC_D =
    512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [511:0] EMPTY_D =
    512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  H_in;
  logic [1023:0] M_in;
  logic          input_valid;
  logic [511:0]  H_out;
  logic          output_valid;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  typedef struct {
    string         name;
    logic [511:0]  h;
    logic [1023:0] m;
    logic [511:0]  exp;
  } vec_t;

  vec_t vecs [2];

  sha512_block_core dut (
    .clk          (clk),
    .rst          (rst),
    .H_in         (H_in),
    .M_in         (M_in),
    .input_valid  (input_valid),
    .H_out        (H_out),
    .output_valid (output_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (output_valid === 1'b1) pulse_cnt++;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [511:0] h, input logic [1023:0] m);
    @(negedge clk);
    H_in = h;
    M_in = m;
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  // Counts negedges until output_valid is seen; bounded so a dead DUT still ends.
  task automatic wait_pulse(output int n);
    n = 0;
    while (output_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, n2, p0, bad;
    logic [511:0] d;

    vecs[0] = '{name: "abc",   h: IV, m: ABC_M,   exp: ABC_D};
    vecs[1] = '{name: "empty", h: IV, m: EMPTY_M, exp: EMPTY_D};

    rst = 1'b0;
    H_in = '0;
    M_in = '0;
    input_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hout", H_out, 512'h0);
    check("reset_ov", {511'h0, output_valid}, 512'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      start(vecs[i].h, vecs[i].m);
      wait_pulse(n);
      check({vecs[i].name, "_latency"}, n, LAT);
      check({vecs[i].name, "_digest"}, H_out, vecs[i].exp);
      d = H_out;
      @(negedge clk);
      check({vecs[i].name, "_pulse_width"}, {511'h0, output_valid}, 512'h0);
      check({vecs[i].name, "_hold"}, H_out, d);
    end

    // Busy-ignore: a second request mid-run must not disturb the first.
    p0 = pulse_cnt;
    start(IV, ABC_M);
    repeat (38) @(negedge clk);
    H_in = '0;
    M_in = EMPTY_M;
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    wait_pulse(n);
    check("busy_latency", n + 39, LAT);
    check("busy_digest", H_out, ABC_D);
    repeat (100) @(negedge clk);
    check("busy_pulse_count", pulse_cnt - p0, 1);

    // Reset mid-run aborts without a pulse.
    start(IV, ABC_M);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_hout", H_out, 512'h0);
    check("midreset_ov", {511'h0, output_valid}, 512'h0);
    @(negedge clk);
    rst = 1'b1;
    p0 = pulse_cnt;
    repeat (120) @(negedge clk);
    check("midreset_no_pulse", pulse_cnt - p0, 0);
    start(IV, ABC_M);
    wait_pulse(n);
    check("after_reset_latency", n, LAT);
    check("after_reset_digest", H_out, ABC_D);
    @(negedge clk);

    // Back-to-back: new start on the edge right after the pulse.
    start(IV, ABC_M);
    wait_pulse(n);
    check("b2b_first_digest", H_out, ABC_D);
    H_in = IV;
    M_in = EMPTY_M;
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    wait_pulse(n2);
    check("b2b_spacing", n2 + 1, LAT + 1);
    check("b2b_second_digest", H_out, EMPTY_D);

    // Idle hold.
    d = H_out;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (H_out !== d || output_valid !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);
    check("idle_hold_value", H_out, EMPTY_D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
